// File: rtl/gac_mux_pipe_nt1.sv
// Two-stage pipelined N-to-1 mux with valid/ready flow control: stage 1 picks within groups, stage 2 picks the group.
// Optional out-of-range select flag on sel_err when GAC_MUX_SEL_CHECK_EN is defined.
module gac_mux_pipe_nt1 #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 32,
    parameter int GRP    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IN*WIDTH-1:0]   x,
    input  logic [$clog2(NUM_IN)-1:0] sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          q,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef GAC_MUX_SEL_CHECK_EN
    ,
    output logic                      sel_err
`endif
);

    localparam int SEL_W = $clog2(NUM_IN);
    localparam int GRP_W = $clog2(GRP);
    localparam int NGRP  = (NUM_IN + GRP - 1) / GRP;
    localparam int HI_W  = (SEL_W > GRP_W) ? SEL_W - GRP_W : 1;

    logic                 s1_valid;
    logic [HI_W-1:0]      s1_hi;
    logic [WIDTH-1:0]     s1_g [NGRP];
    logic [WIDTH-1:0]     g_d  [NGRP];
    logic [HI_W-1:0]      sel_hi_d;
    logic [WIDTH-1:0]     q_d;
    logic                 s2_adv;
    logic                 s1_adv;

    assign s2_adv   = ~out_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;

    if (SEL_W > GRP_W) begin : g_hi
        assign sel_hi_d = sel[SEL_W-1:GRP_W];
    end else begin : g_nohi
        assign sel_hi_d = '0;
    end

    // Slots beyond NUM_IN (partial last group, out-of-range sel) read as zero.
    always_comb begin
        for (int k = 0; k < NGRP; k++) begin
            g_d[k] = '0;
            if (k * GRP + int'(sel[GRP_W-1:0]) < NUM_IN) begin
                g_d[k] = x[(k * GRP + int'(sel[GRP_W-1:0])) * WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        q_d = '0;
        for (int k = 0; k < NGRP; k++) begin
            if (int'(s1_hi) == k) begin
                q_d = s1_g[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_hi    <= '0;
            for (int k = 0; k < NGRP; k++) begin
                s1_g[k] <= '0;
            end
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_hi <= sel_hi_d;
                for (int k = 0; k < NGRP; k++) begin
                    s1_g[k] <= g_d[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                q <= q_d;
            end
        end
    end

`ifdef GAC_MUX_SEL_CHECK_EN
    localparam logic [SEL_W:0] NUM_IN_V = (SEL_W + 1)'(NUM_IN);

    logic s1_err;

    // The error flag travels with its item through both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_err  <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            if (s1_adv && in_valid) begin
                s1_err <= ({1'b0, sel} >= NUM_IN_V);
            end
            if (s2_adv && s1_valid) begin
                sel_err <= s1_err;
            end
        end
    end
`else
    // Without the check, out-of-range selects still return zero through the index guards.
`endif

endmodule
